// File: rtl/transmit_counter.sv
// -----------------------------------------------------------------------------
// transmit_counter
//
// Burst serializer for the ultrasound transmit path. A 32-bit pulse-shape word
// is captured when a burst starts and shifted out MSB-first, one bit per clock,
// for a programmable number of bits (0..255). If the burst is longer than 32
// bits, the pattern wraps back to bit 31. The transmit-control FSM can pause a
// running burst with counter_in_use_i. While paused, the line is held low and
// no bit is consumed.
//
// Ports
//   clk_i               system clock, all logic on the rising edge
//   rst_ni              asynchronous, active-low reset
//   counter_in_use_i    1 = transmit path owned elsewhere: inhibit start,
//                       pause a running burst
//   start_count_i       start request, sampled each rising edge
//   upload_new_count_i  load count_i into the burst-length register
//   count_i[7:0]        burst length in bits
//   pulse_shape_i[31:0] transmit bit pattern, bit 31 sent first
//   ultrasound_pulse_o  serialized transmit bit (registered)
//   pulse_sent_o        one-cycle strobe on the cycle after the last bit
//   count_complete_o    sticky: last burst finished, no upload/start since
// -----------------------------------------------------------------------------
module transmit_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        counter_in_use_i,
  input  logic        start_count_i,
  input  logic        upload_new_count_i,
  input  logic [7:0]  count_i,
  input  logic [31:0] pulse_shape_i,
  output logic        ultrasound_pulse_o,
  output logic        pulse_sent_o,
  output logic        count_complete_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  len_q;
  logic [31:0] shape_q;
  logic [4:0]  bit_idx_q;
  logic [7:0]  remaining_q;
  logic        pulse_q;
  logic        sent_q;
  logic        complete_q;

  // Burst length seen by a start in the same cycle: an upload in that cycle
  // takes effect first, so the start uses the freshly loaded count.
  logic [7:0]  len_d;
  logic        start_ok;

  always_comb begin
    len_d    = upload_new_count_i ? count_i : len_q;
    start_ok = start_count_i && !counter_in_use_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      shape_q     <= 32'd0;
      bit_idx_q   <= 5'd31;
      remaining_q <= 8'd0;
      pulse_q     <= 1'b0;
      sent_q      <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          pulse_q <= 1'b0;
          len_q   <= len_d;
          if (upload_new_count_i) begin
            complete_q <= 1'b0;
            state_q    <= IDLE;
          end
          if (start_ok) begin
            shape_q <= pulse_shape_i;
            if (len_d == 8'd0) begin
              // Empty burst: finish immediately with the line kept low.
              sent_q     <= 1'b1;
              complete_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              // The first bit comes straight from the input word so that it
              // appears on the cycle after the start is sampled.
              complete_q  <= 1'b0;
              pulse_q     <= pulse_shape_i[31];
              bit_idx_q   <= 5'd30;
              remaining_q <= len_d - 8'd1;
              state_q     <= SEND;
            end
          end
        end

        SEND: begin
          if (counter_in_use_i) begin
            // Pause: the line is low and the position is frozen.
            pulse_q <= 1'b0;
          end else if (remaining_q != 8'd0) begin
            pulse_q     <= shape_q[bit_idx_q];
            // A 5-bit index naturally wraps from 0 back to 31.
            bit_idx_q   <= bit_idx_q - 5'd1;
            remaining_q <= remaining_q - 8'd1;
          end else begin
            pulse_q    <= 1'b0;
            sent_q     <= 1'b1;
            complete_q <= 1'b1;
            state_q    <= DONE;
          end
        end

        default: begin
          pulse_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ultrasound_pulse_o = pulse_q;
  assign pulse_sent_o       = sent_q;
  assign count_complete_o   = complete_q;

endmodule

// File: tb/tb_transmit_counter.sv
module tb_transmit_counter;

  logic        clk;
  logic        rst_n;
  logic        in_use;
  logic        start;
  logic        upload;
  logic [7:0]  count;
  logic [31:0] shape;
  logic        pulse;
  logic        sent;
  logic        complete;

  int n_cmp = 0;
  int n_err = 0;

  transmit_counter dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .counter_in_use_i   (in_use),
    .start_count_i      (start),
    .upload_new_count_i (upload),
    .count_i            (count),
    .pulse_shape_i      (shape),
    .ultrasound_pulse_o (pulse),
    .pulse_sent_o       (sent),
    .count_complete_o   (complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the start edge. Checks n bits on consecutive cycles,
  // each given as an expected bit string (bit n-1 first). Optionally pauses
  // after bit index pause_at for pause_len cycles. During the pause, it also
  // asserts start and upload, and changes the input shape. All of these must
  // be ignored.
  task automatic check_burst(input string tag, input int n, input logic [63:0] exp_bits,
                             input int pause_at, input int pause_len);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s bit%0d", tag, i), 32'(pulse), 32'(exp_bits[n-1-i]));
      chk($sformatf("%s nosent%0d", tag, i), 32'(sent), 32'd0);
      if (i == pause_at) begin
        in_use = 1'b1;
        start  = 1'b1;
        upload = 1'b1;
        count  = 8'd1;
        shape  = 32'h0000_0000;
        for (int p = 0; p < pause_len; p++) begin
          tick();
          chk($sformatf("%s pause%0d", tag, p), 32'(pulse), 32'd0);
          chk($sformatf("%s pausesent%0d", tag, p), 32'(sent), 32'd0);
        end
        in_use = 1'b0;
        start  = 1'b0;
        upload = 1'b0;
        shape  = 32'h5BBD_F7EB;
      end
      tick();
    end
    chk({tag, " end_line"}, 32'(pulse), 32'd0);
    chk({tag, " end_sent"}, 32'(sent), 32'd1);
    chk({tag, " end_cc"}, 32'(complete), 32'd1);
    tick();
    chk({tag, " strobe_off"}, 32'(sent), 32'd0);
    chk({tag, " cc_hold"}, 32'(complete), 32'd1);
  endtask

  logic [63:0] bits40;

  initial begin
    rst_n  = 1'b0;
    in_use = 1'b0;
    start  = 1'b0;
    upload = 1'b0;
    count  = 8'd0;
    shape  = 32'h5BBD_F7EB;
    tick();
    tick();
    chk("rst line", 32'(pulse), 32'd0);
    chk("rst sent", 32'(sent), 32'd0);
    chk("rst cc", 32'(complete), 32'd0);
    rst_n = 1'b1;
    tick();

    // Upload 4, then start: 0,1,0,1.
    count = 8'd4; upload = 1'b1; tick(); upload = 1'b0;
    chk("up4 cc", 32'(complete), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_burst("b4", 4, 64'b0101, -1, 0);
    tick();
    chk("b4 cc_held", 32'(complete), 32'd1);

    // A start while in_use is high is ignored and leaves completion set.
    in_use = 1'b1; start = 1'b1; tick(); start = 1'b0;
    chk("inuse_start line", 32'(pulse), 32'd0);
    chk("inuse_start sent", 32'(sent), 32'd0);
    chk("inuse_start cc", 32'(complete), 32'd1);
    in_use = 1'b0; tick();
    chk("inuse_start idle", 32'(pulse), 32'd0);

    // A repeated start reuses the stored length of 4.
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun cc_drop", 32'(complete), 32'd0);
    check_burst("rerun", 4, 64'b0101, -1, 0);

    // Upload 5: completion drops. Then start: 0,1,0,1,1.
    count = 8'd5; upload = 1'b1; tick(); upload = 1'b0;
    chk("up5 cc", 32'(complete), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_burst("b5", 5, 64'b01011, -1, 0);

    // Upload 40 and start in the same cycle. The pattern wraps after 32 bits.
    // Pause after bit 10 for 3 cycles. Start, upload and shape changes
    // during the pause are all ignored.
    bits40 = {8'h00, 32'h5BBD_F7EB, 8'b0101_1011, 16'h0000};
    count = 8'd40; upload = 1'b1; start = 1'b1; tick(); upload = 1'b0; start = 1'b0;
    chk("b40 cc_drop", 32'(complete), 32'd0);
    check_burst("b40", 40, bits40 >> 16, 10, 3);

    // Upload 0 and start together: complete on the next cycle with no bits.
    count = 8'd0; upload = 1'b1; start = 1'b1; tick(); upload = 1'b0; start = 1'b0;
    chk("b0 line", 32'(pulse), 32'd0);
    chk("b0 sent", 32'(sent), 32'd1);
    chk("b0 cc", 32'(complete), 32'd1);
    tick();
    chk("b0 strobe_off", 32'(sent), 32'd0);

    // Reset in the middle of a 5-bit burst.
    count = 8'd5; upload = 1'b1; tick(); upload = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("pre_rst bit1", 32'(pulse), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst line", 32'(pulse), 32'd0);
    chk("midrst sent", 32'(sent), 32'd0);
    chk("midrst cc", 32'(complete), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst sent", 32'(sent), 32'd0);

    // No upload since reset, so the stored length is 0 and the burst is empty.
    start = 1'b1; tick(); start = 1'b0;
    chk("len0 line", 32'(pulse), 32'd0);
    chk("len0 sent", 32'(sent), 32'd1);
    chk("len0 cc", 32'(complete), 32'd1);
    tick();
    chk("len0 strobe_off", 32'(sent), 32'd0);
    chk("len0 cc_hold", 32'(complete), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
